// File: rtl/pwm_sample_sequencer.sv
// Feeds the PWM stage one buffered mixer sample per frame. Samples are queued in
// a small FIFO, and the pwm enable is held for whole frames only.
module pwm_sample_sequencer #(
  parameter int          DEPTH       = 4,
  parameter int          FRAME_LEN   = 256,
  parameter int          PRIME_LEVEL = 2,
  parameter logic [7:0]  IDLE_SAMPLE = 8'd0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] in_sample,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] mixed_sample,
  output logic       pwm_enable,
  output logic       frame_strobe,
  output logic       underrun,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FRAME_LEN);
  localparam logic [FW-1:0] LAST_CNT = FW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state;
  logic [FW-1:0]   frame_cnt;
  logic            stop_pend;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr_next;

  logic            push;
  logic            pop;
  logic            flush;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Pop and flush both happen only on a frame-load edge; the FSM below mirrors this.
  always_comb begin
    pop   = 1'b0;
    flush = 1'b0;
    case (state)
      PRIME: pop = !stop && (count >= CW'(PRIME_LEVEL));
      RUN: begin
        if (frame_cnt == LAST_CNT) begin
          if (stop_pend || stop) flush = 1'b1;
          else                   pop   = (count != '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr;
    if (push) wr_ptr_next = wr_ptr + 1'b1;
  end

  // Storage array has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sample;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      if (flush) begin
        // A push landing on the flush edge is discarded along with the rest.
        rd_ptr <= wr_ptr_next;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      stop_pend    <= 1'b0;
      mixed_sample <= IDLE_SAMPLE;
      pwm_enable   <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          pwm_enable   <= 1'b0;
          mixed_sample <= IDLE_SAMPLE;
          if (start && !stop) begin
            state    <= PRIME;
            underrun <= 1'b0;
          end
        end
        PRIME: begin
          if (stop) begin
            state <= IDLE;
          end else if (pop) begin
            mixed_sample <= mem[rd_ptr];
            pwm_enable   <= 1'b1;
            frame_cnt    <= '0;
            frame_strobe <= 1'b1;
            stop_pend    <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (frame_cnt == LAST_CNT) begin
            frame_cnt <= '0;
            if (flush) begin
              state        <= IDLE;
              pwm_enable   <= 1'b0;
              mixed_sample <= IDLE_SAMPLE;
              stop_pend    <= 1'b0;
            end else begin
              frame_strobe <= 1'b1;
              if (pop) mixed_sample <= mem[rd_ptr];
              else     underrun     <= 1'b1;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (stop) stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer with DEPTH=4, FRAME_LEN=256, PRIME_LEVEL=2.
module tb_pwm_sample_sequencer;

  logic       clk;
  logic       nrst;
  logic [7:0] in_sample;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic       stop;
  logic [7:0] mixed_sample;
  logic       pwm_enable;
  logic       frame_strobe;
  logic       underrun;
  logic       busy;

  int total;
  int bad;

  pwm_sample_sequencer #(
    .DEPTH(4), .FRAME_LEN(256), .PRIME_LEVEL(2), .IDLE_SAMPLE(8'd0)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .stop(stop),
    .mixed_sample(mixed_sample), .pwm_enable(pwm_enable),
    .frame_strobe(frame_strobe), .underrun(underrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; in_sample = 8'h00; in_valid = 1'b0; start = 1'b0; stop = 1'b0;
    #23;
    total++; if (pwm_enable !== 1'b0) begin bad++; $display("FAIL reset_pwm_enable got=%b want=0", pwm_enable); end
    total++; if (mixed_sample !== 8'h00) begin bad++; $display("FAIL reset_mixed got=%h want=00", mixed_sample); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({frame_strobe, underrun} !== 2'b00) begin bad++; $display("FAIL reset_strobe_underrun got=%b want=00", {frame_strobe, underrun}); end
    @(negedge clk);
    nrst = 1'b1;
    tick(2);
    total++; if ({pwm_enable, busy, in_ready, mixed_sample} !== {3'b001, 8'h00}) begin bad++;
      $display("FAIL post_release got=%b want=%b", {pwm_enable, busy, in_ready, mixed_sample}, {3'b001, 8'h00}); end
    $display("transaction: reset checked");
  endtask

  task automatic test_start_stop_same;
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_stop_same busy got=%b want=0", busy); end
    $display("transaction: start+stop together in IDLE");
  endtask

  task automatic test_play;
    logic mid_bad;
    in_valid = 1'b1; in_sample = 8'h7F;
    tick(1);
    in_sample = 8'h10;
    tick(1);
    in_valid = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if ({busy, pwm_enable, frame_strobe} !== 3'b100) begin bad++;
      $display("FAIL prime_state got=%b want=100", {busy, pwm_enable, frame_strobe}); end
    tick(1);
    total++; if ({frame_strobe, pwm_enable, mixed_sample} !== {2'b11, 8'h7F}) begin bad++;
      $display("FAIL first_load got=%b_%h want=11_7f", {frame_strobe, pwm_enable}, mixed_sample); end
    mid_bad = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick(1);
      if (mixed_sample !== 8'h7F || frame_strobe !== 1'b0 || pwm_enable !== 1'b1) mid_bad = 1'b1;
    end
    total++; if (mid_bad !== 1'b0) begin bad++; $display("FAIL frame1_stable got=1 want=0"); end
    tick(1);
    total++; if ({frame_strobe, mixed_sample, underrun} !== {1'b1, 8'h10, 1'b0}) begin bad++;
      $display("FAIL second_load got=%b_%h_%b want=1_10_0", frame_strobe, mixed_sample, underrun); end
    $display("transaction: two-sample playback");
  endtask

  task automatic test_underrun;
    int waited;
    tick(256);
    total++; if ({frame_strobe, mixed_sample, underrun} !== {1'b1, 8'h10, 1'b1}) begin bad++;
      $display("FAIL underrun_set got=%b_%h_%b want=1_10_1", frame_strobe, mixed_sample, underrun); end
    tick(256);
    total++; if ({frame_strobe, underrun, mixed_sample} !== {2'b11, 8'h10}) begin bad++;
      $display("FAIL underrun_sticky got=%b_%b_%h want=1_1_10", frame_strobe, underrun, mixed_sample); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 300) begin tick(1); waited++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_timeout busy got=%b want=0", busy); end
    total++; if ({pwm_enable, underrun} !== 2'b01) begin bad++;
      $display("FAIL after_stop got=%b want=01", {pwm_enable, underrun}); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if ({underrun, busy} !== 2'b01) begin bad++;
      $display("FAIL start_clears_underrun got=%b want=01", {underrun, busy}); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prime_stop busy got=%b want=0", busy); end
    $display("transaction: underrun and clear");
  endtask

  task automatic test_fifo_full_and_stop;
    logic [7:0] vals [5];
    logic       en_bad;
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4; vals[4] = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sample = vals[i];
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b want=1", i, in_ready); end
      tick(1);
    end
    in_sample = vals[4];
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", in_ready); end
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_prime got=%b want=0", in_ready); end
    tick(1);
    total++; if ({frame_strobe, mixed_sample, in_ready} !== {1'b1, 8'hA1, 1'b1}) begin bad++;
      $display("FAIL pop_frees_slot got=%b_%h_%b want=1_a1_1", frame_strobe, mixed_sample, in_ready); end
    tick(1);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fifth_accepted got=%b want=0", in_ready); end
    // frame_cnt is now 1; bring it to 100 and request a stop there.
    tick(99);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    en_bad = 1'b0;
    for (int i = 0; i < 154; i++) begin
      if (pwm_enable !== 1'b1 || busy !== 1'b1 || mixed_sample !== 8'hA1) en_bad = 1'b1;
      tick(1);
    end
    total++; if (en_bad !== 1'b0 || pwm_enable !== 1'b1) begin bad++;
      $display("FAIL stop_frame_completes got=%b want=0", en_bad); end
    tick(1);
    total++; if ({pwm_enable, busy, in_ready, frame_strobe, mixed_sample} !== {4'b0010, 8'h00}) begin bad++;
      $display("FAIL stop_to_idle got=%b want=%b", {pwm_enable, busy, in_ready, frame_strobe, mixed_sample}, {4'b0010, 8'h00}); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    en_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (pwm_enable !== 1'b0 || frame_strobe !== 1'b0 || busy !== 1'b1) en_bad = 1'b1;
    end
    total++; if (en_bad !== 1'b0) begin bad++; $display("FAIL fifo_flushed got=%b want=0", en_bad); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    $display("transaction: fifo full, stop at frame_cnt 100");
  endtask

  task automatic test_reset_mid_run;
    in_valid = 1'b1; in_sample = 8'h55;
    tick(1);
    in_sample = 8'h66;
    tick(1);
    in_valid = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    total++; if ({pwm_enable, mixed_sample} !== {1'b1, 8'h55}) begin bad++;
      $display("FAIL mid_run_load got=%b_%h want=1_55", pwm_enable, mixed_sample); end
    tick(40);
    #2 nrst = 1'b0;
    #1;
    total++; if ({pwm_enable, mixed_sample, busy, in_ready, underrun} !== {1'b0, 8'h00, 3'b010}) begin bad++;
      $display("FAIL async_reset got=%b_%h_%b want=0_00_010", pwm_enable, mixed_sample, {busy, in_ready, underrun}); end
    @(negedge clk);
    nrst = 1'b1;
    tick(1);
    total++; if ({pwm_enable, busy} !== 2'b00) begin bad++;
      $display("FAIL after_async_reset got=%b want=00", {pwm_enable, busy}); end
    $display("transaction: async reset mid-run");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_start_stop_same;
    test_play;
    test_underrun;
    test_fifo_full_and_stop;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
